// File: rtl/rib_pkg.sv
// Shared definitions for the RIB master arbiter: arbitration mode encodings
// and the index-width helper used to size master IDs.
package rib_pkg;

   localparam int RIB_ARB_FIXED = 0;
   localparam int RIB_ARB_RR    = 1;

   // A single master still needs one bit to carry its ID.
   function automatic int rib_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rib_id_fifo.sv
// In-order FIFO of granted master IDs; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module rib_id_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_q, wr_d;
   logic [PW:0]      rd_q, rd_d;
   logic             do_push;
   logic             do_pop;

   assign o_empty = (wr_q == rd_q);
   assign o_full  = (wr_q[PW-1:0] == rd_q[PW-1:0]) && (wr_q[PW] != rd_q[PW]);
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;
   assign wr_d    = wr_q + {{PW{1'b0}}, do_push};
   assign rd_d    = rd_q + {{PW{1'b0}}, do_pop};
   assign o_rdata = mem_q[rd_q[PW-1:0]];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_q[wr_q[PW-1:0]] <= i_wdata;
      end
   end

endmodule

// File: rtl/rib_master_arb.sv
// N-to-1 RIB master arbiter: combinational request/response pass-through with
// selection lock, fixed or round-robin priority, and an in-order ID FIFO.
module rib_master_arb
   import rib_pkg::*;
#(
   parameter int NM   = 2,
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int OSTD = 4,
   parameter int MODE = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NM*AW-1:0]     i_m_addr,
   input  logic [NM-1:0]        i_m_wrcs,
   input  logic [NM*DW/8-1:0]   i_m_mask,
   input  logic [NM*DW-1:0]     i_m_wdata,
   input  logic [NM-1:0]        i_m_req,
   output logic [NM-1:0]        o_m_gnt,
   output logic [NM*DW-1:0]     o_m_rdata,
   output logic [NM-1:0]        o_m_rsp,
   input  logic [NM-1:0]        i_m_rdy,
   output logic [AW-1:0]        o_s_addr,
   output logic                 o_s_wrcs,
   output logic [DW/8-1:0]      o_s_mask,
   output logic [DW-1:0]        o_s_wdata,
   output logic                 o_s_req,
   input  logic                 i_s_gnt,
   input  logic [DW-1:0]        i_s_rdata,
   input  logic                 i_s_rsp,
   output logic                 o_s_rdy,
   output logic                 o_err
);

   localparam int IW = rib_idx_w(NM);
   localparam int MW = DW / 8;

   logic          lock_q, lock_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic          err_q, err_d;
   logic [IW-1:0] sel;
   logic          sel_vld;
   int            start;
   logic          accept;
   logic          rsp_xfer;
   logic          fifo_full;
   logic          fifo_empty;
   logic [IW-1:0] head;

   // A stalled master keeps the slave port until accepted or it withdraws.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      start   = (MODE == RIB_ARB_FIXED) ? 0 : int'(ptr_q);
      if (lock_q && i_m_req[lock_idx_q]) begin
         sel     = lock_idx_q;
         sel_vld = 1'b1;
      end else begin
         for (int i = 0; i < NM; i++) begin
            if (!sel_vld && i_m_req[(start + i) % NM]) begin
               sel     = IW'((start + i) % NM);
               sel_vld = 1'b1;
            end
         end
      end
   end

   assign o_s_req = !i_rst && sel_vld && !fifo_full;
   assign accept  = o_s_req && i_s_gnt;

   always_comb begin
      o_s_addr  = '0;
      o_s_wrcs  = 1'b0;
      o_s_mask  = '0;
      o_s_wdata = '0;
      o_m_gnt   = '0;
      for (int k = 0; k < NM; k++) begin
         if (sel == IW'(k)) begin
            o_s_addr   = i_m_addr[k*AW +: AW];
            o_s_wrcs   = i_m_wrcs[k];
            o_s_mask   = i_m_mask[k*MW +: MW];
            o_s_wdata  = i_m_wdata[k*DW +: DW];
            o_m_gnt[k] = o_s_req && i_s_gnt;
         end
      end
   end

   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      ptr_d      = ptr_q;
      if (lock_q && !i_m_req[lock_idx_q]) begin
         lock_d = 1'b0;
      end
      if (o_s_req && !i_s_gnt) begin
         lock_d     = 1'b1;
         lock_idx_d = sel;
      end
      if (accept) begin
         lock_d = 1'b0;
         ptr_d  = IW'((int'(sel) + 1) % NM);
      end
   end

   // Responses return in issue order; with nothing outstanding they are
   // swallowed and flagged.
   always_comb begin
      o_m_rsp   = '0;
      o_m_rdata = '0;
      o_s_rdy   = 1'b0;
      err_d     = 1'b0;
      if (!i_rst) begin
         if (fifo_empty) begin
            o_s_rdy = 1'b1;
            err_d   = i_s_rsp;
         end else begin
            for (int k = 0; k < NM; k++) begin
               if (head == IW'(k)) begin
                  o_s_rdy                = i_m_rdy[k];
                  o_m_rsp[k]             = i_s_rsp;
                  o_m_rdata[k*DW +: DW]  = i_s_rdata;
               end
            end
         end
      end
   end

   assign rsp_xfer = i_s_rsp && o_s_rdy && !fifo_empty;
   assign o_err    = err_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         ptr_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         ptr_q      <= ptr_d;
         err_q      <= err_d;
      end
   end

   rib_id_fifo #(
      .DEPTH (OSTD),
      .WIDTH (IW)
   ) u_id_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (accept),
      .i_wdata (sel),
      .i_pop   (rsp_xfer),
      .o_rdata (head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

endmodule
